// File: rtl/tcm_loader.sv
// rtl/tcm_loader.sv - byte-stream preloader for TCMs with core reset/run control
module tcm_loader #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int NUM_MEM   = 2,
   parameter int RUN_LIMIT = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic [NUM_MEM-1:0]  mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                core_rst,
   output logic                running,
   output logic                timeout,
   output logic                err,
   output logic [15:0]         words_written
);

   localparam int BYTES = DATA_W / 8;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_RUN
   } state_t;

   state_t state, state_nx;

   logic [3:0]        sel_q;
   logic [7:0]        addr_lo_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       cnt_q;
   logic [DATA_W-1:0] word_q;
   logic [BW-1:0]     bidx_q;
   logic [31:0]       run_cnt;

   logic        rx_fire;
   logic [3:0]  cmd;
   logic [3:0]  hdr_sel;
   logic        hdr_sel_ok;
   logic        sel_ok;
   logic        last_byte;
   logic        limit_hit;
   logic        halt_req;
   logic [15:0] addr_full;
   logic [15:0] cnt_full;

   assign rx_fire    = rx_valid & rx_ready;
   assign cmd        = rx_data[7:4];
   assign hdr_sel    = rx_data[3:0];
   assign hdr_sel_ok = (32'(hdr_sel) < NUM_MEM);
   assign sel_ok     = (32'(sel_q) < NUM_MEM);
   assign last_byte  = (bidx_q == BW'(BYTES - 1));
   assign limit_hit  = (RUN_LIMIT != 0) && (run_cnt == 32'(RUN_LIMIT - 1));
   assign halt_req   = rx_fire && (cmd == 4'd3);
   assign addr_full  = {rx_data, addr_lo_q};
   assign cnt_full   = {rx_data, cnt_q[7:0]};

   // Word address and data are held in registers and presented continuously;
   // only the strobe qualifies them.
   assign mem_addr  = addr_q;
   assign mem_wdata = word_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; a HALT byte takes priority over the run limit
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (rx_fire) begin
               case (cmd)
                  4'd1:    state_nx = S_ADDR0;
                  4'd2:    state_nx = S_RUN;
                  default: state_nx = S_IDLE;
               endcase
            end
         end
         S_ADDR0: if (rx_fire) state_nx = S_ADDR1;
         S_ADDR1: if (rx_fire) state_nx = S_CNT0;
         S_CNT0:  if (rx_fire) state_nx = S_CNT1;
         S_CNT1:  if (rx_fire) state_nx = (cnt_full == 16'd0) ? S_IDLE : S_DATA;
         S_DATA:  if (rx_fire && last_byte) state_nx = S_WRITE;
         S_WRITE: state_nx = (cnt_q == 16'd1) ? S_IDLE : S_DATA;
         S_RUN: begin
            if (halt_req)       state_nx = S_IDLE;
            else if (limit_hit) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs decoded from state; a bad select keeps the strobe dead while the frame drains
   always_comb begin
      rx_ready = (state != S_WRITE);
      core_rst = (state != S_RUN);
      running  = (state == S_RUN);
      mem_we   = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         mem_we[i] = (state == S_WRITE) && (sel_q == 4'(i));
      end
   end

   // Frame datapath, sticky flags and write counter
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q         <= '0;
         addr_lo_q     <= '0;
         addr_q        <= '0;
         cnt_q         <= '0;
         word_q        <= '0;
         bidx_q        <= '0;
         timeout       <= 1'b0;
         err           <= 1'b0;
         words_written <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_fire) begin
                  sel_q <= hdr_sel;
                  case (cmd)
                     4'd1:    if (!hdr_sel_ok) err <= 1'b1;
                     4'd2:    timeout <= 1'b0;
                     4'd3:    ;
                     default: err <= 1'b1;
                  endcase
               end
            end
            S_ADDR0: if (rx_fire) addr_lo_q <= rx_data;
            S_ADDR1: if (rx_fire) addr_q <= addr_full[ADDR_W-1:0];
            S_CNT0:  if (rx_fire) cnt_q[7:0] <= rx_data;
            S_CNT1: begin
               if (rx_fire) begin
                  cnt_q[15:8] <= rx_data;
                  bidx_q      <= '0;
               end
            end
            S_DATA: begin
               if (rx_fire) begin
                  word_q[{bidx_q, 3'b000} +: 8] <= rx_data;
                  bidx_q <= last_byte ? '0 : bidx_q + BW'(1);
               end
            end
            S_WRITE: begin
               addr_q <= addr_q + ADDR_W'(1);
               cnt_q  <= cnt_q - 16'd1;
               if (sel_ok && (words_written != 16'hFFFF))
                  words_written <= words_written + 16'd1;
            end
            S_RUN: begin
               if (rx_fire && (cmd != 4'd3)) err <= 1'b1;
               if (limit_hit && !halt_req)   timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Run cycle counter: zero outside RUN, so every entry starts from zero
   always_ff @(posedge clk) begin
      if (rst || (state != S_RUN)) run_cnt <= '0;
      else                         run_cnt <= run_cnt + 32'd1;
   end

endmodule

// File: tb/tb_tcm_loader.sv
// tb/tb_tcm_loader.sv - directed self-checking bench for tcm_loader
module tb_tcm_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [1:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst;
   logic        running;
   logic        timeout;
   logic        err;
   logic [15:0] words_written;

   int checks = 0;
   int failures = 0;

   logic [31:0] log_we[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   logic [31:0] log_rdy[$];

   always #5 clk = ~clk;

   tcm_loader #(.ADDR_W(10), .DATA_W(32), .NUM_MEM(2), .RUN_LIMIT(200)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
      .running(running), .timeout(timeout), .err(err), .words_written(words_written)
   );

   // Record every write strobe seen mid-cycle
   always @(negedge clk) begin
      if (mem_we != 2'b00) begin
         log_we.push_back(32'(mem_we));
         log_addr.push_back(32'(mem_addr));
         log_data.push_back(mem_wdata);
         log_rdy.push_back(32'(rx_ready));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("byte_accepted", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_running"}, 32'(running), 32'd0);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_words"}, 32'(words_written), 32'd0);
   endtask

   initial begin
      int base;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single ITCM word at address 0
      base = log_we.size();
      send(8'h10); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
      send(8'h93); send(8'h00); send(8'h10); send(8'h00);
      settle(); settle();
      check("t1_nwrites", 32'(log_we.size() - base), 32'd1);
      check("t1_we", log_we[base], 32'h1);
      check("t1_addr", log_addr[base], 32'h0);
      check("t1_data", log_data[base], 32'h00100093);
      check("t1_rdy_low", log_rdy[base], 32'd0);
      check("t1_core_rst", 32'(core_rst), 32'd1);
      check("t1_words", 32'(words_written), 32'd1);

      // DTCM, two words across the address wrap
      base = log_we.size();
      send(8'h11); send(8'hFF); send(8'h03); send(8'h02); send(8'h00);
      send(8'h05); send(8'h00); send(8'h00); send(8'h00);
      send(8'h0A); send(8'h00); send(8'h00); send(8'h00);
      settle(); settle();
      check("t2_nwrites", 32'(log_we.size() - base), 32'd2);
      check("t2_we0", log_we[base], 32'h2);
      check("t2_addr0", log_addr[base], 32'h3FF);
      check("t2_data0", log_data[base], 32'h5);
      check("t2_rdy0", log_rdy[base], 32'd0);
      check("t2_we1", log_we[base+1], 32'h2);
      check("t2_addr1", log_addr[base+1], 32'h000);
      check("t2_data1", log_data[base+1], 32'hA);
      check("t2_rdy1", log_rdy[base+1], 32'd0);
      check("t2_words", 32'(words_written), 32'd3);
      check("t2_err", 32'(err), 32'd0);

      // Bad select: frame drained, no strobe, err raised
      base = log_we.size();
      send(8'h12); send(8'h04); send(8'h00); send(8'h01); send(8'h00);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      settle(); settle();
      check("t3_nwrites", 32'(log_we.size() - base), 32'd0);
      check("t3_err", 32'(err), 32'd1);
      check("t3_idle_ready", 32'(rx_ready), 32'd1);
      check("t3_core_rst", 32'(core_rst), 32'd1);

      // Run limit: exactly 200 cycles of released core, then timeout
      do_reset();
      send(8'h20);
      check("t4_running", 32'(running), 32'd1);
      n = 0;
      while (n < 1000) begin
         @(negedge clk);
         if (core_rst == 1'b0) n++;
         else break;
      end
      check("t4_run_cycles", 32'(n), 32'd200);
      check("t4_core_rst", 32'(core_rst), 32'd1);
      check("t4_timeout", 32'(timeout), 32'd1);
      check("t4_running_off", 32'(running), 32'd0);
      send(8'h20);
      check("t4_timeout_cleared", 32'(timeout), 32'd0);
      check("t4_rerun", 32'(running), 32'd1);
      send(8'h30);
      check("t4_halted", 32'(core_rst), 32'd1);

      // Halt after 10 cycles
      send(8'h20);
      repeat (10) @(negedge clk);
      check("t5_core_released", 32'(core_rst), 32'd0);
      send(8'h30);
      check("t5_halt_core_rst", 32'(core_rst), 32'd1);
      check("t5_halt_running", 32'(running), 32'd0);
      check("t5_halt_timeout", 32'(timeout), 32'd0);

      // Stray write header while running
      send(8'h20);
      check("t5_err_before", 32'(err), 32'd0);
      send(8'h10);
      check("t5_err_set", 32'(err), 32'd1);
      check("t5_still_running", 32'(running), 32'd1);
      check("t5_still_core_low", 32'(core_rst), 32'd0);
      send(8'h30);
      check("t5_final_halt", 32'(core_rst), 32'd1);

      // Reset mid-word discards the partial write
      do_reset();
      base = log_we.size();
      send(8'h10); send(8'h05); send(8'h00); send(8'h01); send(8'h00);
      send(8'hAA); send(8'hBB); send(8'hCC);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("t6_midrst");
      check("t6_nwrites", 32'(log_we.size() - base), 32'd0);
      rst = 1'b0;
      send(8'h10); send(8'h07); send(8'h00); send(8'h01); send(8'h00);
      send(8'h44); send(8'h33); send(8'h22); send(8'h11);
      settle(); settle();
      check("t6_nwrites_after", 32'(log_we.size() - base), 32'd1);
      check("t6_we", log_we[base], 32'h1);
      check("t6_addr", log_addr[base], 32'h7);
      check("t6_data", log_data[base], 32'h11223344);
      check("t6_words", 32'(words_written), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tcm_loader.md
Name: tcm_loader

Overview:
- Hardware program/data preloader for the SoC tightly-coupled memories (ITCM, DTCM, further TCMs per parameter).
- Accepts a byte stream (UART/debug bridge) carrying write frames and run/halt commands.
- Writes whole words into the selected TCM write port, holds the core in reset while loading, then releases it.
- An optional run-cycle limit re-asserts core reset and flags a timeout.

Parameters:
- ADDR_W, 10, word-address width of each TCM (1024 words).
- DATA_W, 32, TCM word width; must be a multiple of 8; BYTES = DATA_W/8.
- NUM_MEM, 2, number of TCM targets (0 = ITCM, 1 = DTCM); range 1..16.
- RUN_LIMIT, 200, cycles the core may run before forced halt; 0 disables the limit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  stream byte
- rx_valid  in  1  byte valid
- rx_ready  out  1  loader accepts byte; transfer when rx_valid & rx_ready
- mem_we  out  NUM_MEM  one-hot write strobe, bit i = TCM i
- mem_addr  out  ADDR_W  word address, shared by all TCMs
- mem_wdata  out  DATA_W  write data, shared
- core_rst  out  1  active-high core reset hold
- running  out  1  core released
- timeout  out  1  sticky; RUN_LIMIT reached
- err  out  1  sticky; bad command or bad memory select
- words_written  out  16  saturating count of TCM writes since reset

Behaviour:
- Clocking and reset: one clock; reset is synchronous, active-high. Reset values are core_rst=1, state IDLE, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, running=0, timeout=0, err=0, words_written=0. Asserting rst mid-frame discards the frame with no partial write.
- Header byte: [7:4] = cmd, [3:0] = sel.
  - cmd 1 (WRITE): header, then addr lo, addr hi, cnt lo, cnt hi, then cnt×BYTES data bytes, little-endian.
  - cmd 2 (RUN): no payload.
  - cmd 3 (HALT): no payload.
- States: IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, WRITE, RUN.
- IDLE transitions:
  - cmd 1 → ADDR0.
  - cmd 2 → RUN: core_rst=0, running=1, timeout cleared, run counter cleared.
  - cmd 3 → stays IDLE, core_rst=1.
  - Other cmd → err=1, stays IDLE.
- WRITE frame sequencing:
  - ADDR0 → ADDR1 → CNT0 → CNT1, one accepted byte each.
  - Address uses the low ADDR_W bits of the 16-bit field.
  - In CNT1, cnt=0 → IDLE with no write; otherwise → DATA.
- DATA state:
  - Shift bytes into the word register, byte k to bits [8k+7:8k].
  - After the BYTES-th byte → WRITE.
- WRITE state (exactly 1 cycle):
  - rx_ready=0.
  - mem_we[sel]=1, mem_addr=current address, mem_wdata=assembled word.
  - Address increments, wrapping modulo 2^ADDR_W.
  - Remaining count decrements; → DATA if nonzero, else IDLE.
  - Latency: write strobe is the cycle after the last data byte handshake.
- sel ≥ NUM_MEM: frame is fully consumed and mem_we stays 0; err=1 at the header.
- RUN state:
  - rx_ready=1; run counter increments each cycle.
  - HALT byte (0x3x) → core_rst=1, running=0, IDLE.
  - Any other byte is consumed and sets err=1; state stays RUN.
  - RUN_LIMIT≠0 and counter reaches RUN_LIMIT−1 → next cycle core_rst=1, running=0, timeout=1, IDLE.
  - HALT and limit in the same cycle → HALT wins, timeout not set.
- mem_we is never asserted outside WRITE; core_rst=1 whenever the state is not RUN.
- words_written increments once per WRITE and saturates at 0xFFFF.

Test Plan:
- Reset then stream 0x10, 0x00, 0x00, 0x01, 0x00, 0x93, 0x00, 0x10, 0x00 → a single mem_we=2'b01 pulse, mem_addr=0, mem_wdata=0x00100093, core_rst stays 1, words_written=1.
- WRITE to DTCM (0x11), addr=0x3FF, cnt=2, words 0x5 and 0xA → writes at addr 0x3FF then 0x000 (wrap), mem_we=2'b10 each time, rx_ready low on both strobe cycles.
- Header 0x12 (sel 2, NUM_MEM=2) with cnt=1 → all 9 bytes consumed, mem_we never set, err=1.
- RUN (0x20), no further input, RUN_LIMIT=200 → core_rst low for exactly 200 cycles, then core_rst=1 and timeout=1; a second RUN clears timeout.
- RUN then HALT (0x30) after 10 cycles → core_rst=1 the cycle after the handshake, timeout=0; a byte 0x10 sent while running → err=1 and state stays RUN.
- rst asserted after 3 of 4 data bytes of a word → no mem_we, all outputs at reset values; a following complete frame writes correctly.
